// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Boots from the word at RESET_VEC, walks the instruction stream one 16-bit word
// per unstalled cycle, joins two-word instructions with their immediate, and
// presents a registered instruction (opcode, register fields, immediate, PC)
// to decode. Supports stall, branch redirect and a terminal HALT state.
module fetch_unit #(
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter logic [6:0]      NOP_OP    = 7'h68
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic [6:0]    opcode,
    output logic [2:0]    rsrc,
    output logic [2:0]    rdst,
    output logic [15:0]   imm,
    output logic          instr_valid,
    output logic [AW-1:0] instr_pc,
    output logic          halted
);

    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_LDM  = 7'b0110101;
    localparam logic [6:0] OP_LDD  = 7'b0100010;
    localparam logic [6:0] OP_STD  = 7'b0100011;
    localparam logic [6:0] OP_HLT  = 7'b1100001;

    typedef enum logic [1:0] {
        S_VEC   = 2'd0,
        S_FETCH = 2'd1,
        S_IMM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q,    state_d;
    logic [AW-1:0] pc_q,       pc_d;
    logic [6:0]    opcode_q,   opcode_d;
    logic [2:0]    rsrc_q,     rsrc_d;
    logic [2:0]    rdst_q,     rdst_d;
    logic [15:0]   imm_q,      imm_d;
    logic          valid_q,    valid_d;
    logic [AW-1:0] ipc_q,      ipc_d;
    logic          halted_q,   halted_d;
    // Only the decoded fields of the first word are kept while the immediate is fetched.
    logic [15:3]   ir_hold_q,  ir_hold_d;
    logic [AW-1:0] pc_hold_q,  pc_hold_d;

    logic [6:0]    word_op;
    logic          unused_low_bits;

    assign word_op         = imem_rdata[15:9];
    assign unused_low_bits = ^imem_rdata[2:0];

    function automatic logic is_two_word(input logic [6:0] op);
        return (op == OP_IADD) || (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
    endfunction

    // Next-state, memory address and next output values; every target defaults to hold.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        rsrc_d    = rsrc_q;
        rdst_d    = rdst_q;
        imm_d     = imm_q;
        valid_d   = valid_q;
        ipc_d     = ipc_q;
        halted_d  = halted_q;
        ir_hold_d = ir_hold_q;
        pc_hold_d = pc_hold_q;
        imem_addr = pc_q;

        case (state_q)
            S_VEC: begin
                // Boot vector fetch ignores stall and branch.
                imem_addr = RESET_VEC;
                pc_d      = imem_rdata[AW-1:0];
                valid_d   = 1'b0;
                opcode_d  = NOP_OP;
                state_d   = S_FETCH;
            end

            S_FETCH: begin
                if (branch_taken) begin
                    pc_d     = branch_target;
                    valid_d  = 1'b0;
                    opcode_d = NOP_OP;
                end else if (!stall) begin
                    pc_d = pc_q + AW'(1);
                    if (is_two_word(word_op)) begin
                        ir_hold_d = imem_rdata[15:3];
                        pc_hold_d = pc_q;
                        valid_d   = 1'b0;
                        opcode_d  = NOP_OP;
                        state_d   = S_IMM;
                    end else begin
                        opcode_d = word_op;
                        rsrc_d   = imem_rdata[8:6];
                        rdst_d   = imem_rdata[5:3];
                        ipc_d    = pc_q;
                        valid_d  = 1'b1;
                        if (word_op == OP_HLT) begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                    end
                end
            end

            S_IMM: begin
                if (branch_taken) begin
                    // Partial two-word instruction is dropped.
                    pc_d      = branch_target;
                    ir_hold_d = '0;
                    valid_d   = 1'b0;
                    opcode_d  = NOP_OP;
                    state_d   = S_FETCH;
                end else if (!stall) begin
                    imm_d    = imem_rdata;
                    opcode_d = ir_hold_q[15:9];
                    rsrc_d   = ir_hold_q[8:6];
                    rdst_d   = ir_hold_q[5:3];
                    ipc_d    = pc_hold_q;
                    pc_d     = pc_q + AW'(1);
                    valid_d  = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            default: begin
                // HALT: pc frozen, branch ignored, left only through reset.
                if (!stall) begin
                    valid_d  = 1'b0;
                    opcode_d = NOP_OP;
                    halted_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_VEC;
            pc_q      <= '0;
            opcode_q  <= NOP_OP;
            rsrc_q    <= '0;
            rdst_q    <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            ipc_q     <= '0;
            halted_q  <= 1'b0;
            ir_hold_q <= '0;
            pc_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            rsrc_q    <= rsrc_d;
            rdst_q    <= rdst_d;
            imm_q     <= imm_d;
            valid_q   <= valid_d;
            ipc_q     <= ipc_d;
            halted_q  <= halted_d;
            ir_hold_q <= ir_hold_d;
            pc_hold_q <= pc_hold_d;
        end
    end

    assign opcode      = opcode_q;
    assign rsrc        = rsrc_q;
    assign rdst        = rdst_q;
    assign imm         = imm_q;
    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;

endmodule
